// File: rtl/hamming_frame_encoder_if.sv
// -----------------------------------------------------------------------------
// hamming_frame_encoder_if
//
// Signal bundle between the Hamming frame encoder and its neighbours: the
// serial payload input handshake, the serial frame output handshake, the
// header select and the frame counter.
//
// Modports:
//   master - the side that feeds payload bits and consumes frame bits
//            (drives in_data, in_valid, hdr_sel, out_ready)
//   slave  - the encoder itself
//            (drives in_ready, out_data, out_valid, out_sof, frame_cnt)
// -----------------------------------------------------------------------------
interface hamming_frame_encoder_if;
    logic       in_data;
    logic       in_valid;
    logic       in_ready;
    logic       hdr_sel;
    logic       out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic [7:0] frame_cnt;

    modport master (
        output in_data,
        output in_valid,
        output hdr_sel,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_sof,
        input  frame_cnt
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  hdr_sel,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_sof,
        output frame_cnt
    );
endinterface

// File: rtl/hamming_frame_encoder.sv
// -----------------------------------------------------------------------------
// hamming_frame_encoder
//
// Bit-serial Hamming frame encoder. Collects 4*N_GROUPS payload bits (first
// bit becomes the payload MSB), encodes every nibble as a Hamming(7,4)
// codeword, prepends an 8-bit sync header chosen by hdr_sel and shifts the
// frame out MSB first. The payload register doubles as the second buffer: a
// complete payload waits there (pending) while the previous frame is still
// shifting, so collection overlaps transmission.
//
// Build option:
//   HAMMING_SECDED_EN - when defined, every codeword gets an overall parity
//                       bit as its MSB (8-bit codewords, SEC-DED).
//
// Ports:
//   clk_in     clock, everything on the rising edge
//   rst        asynchronous, active-high reset
//   bus.slave  in_data/in_valid/in_ready  serial payload handshake
//              hdr_sel                    header select, sampled on load
//              out_data/out_valid/out_ready serial frame handshake
//              out_sof                    high with the first header bit
//              frame_cnt                  frames loaded since reset (wraps)
// -----------------------------------------------------------------------------
module hamming_frame_encoder #(
    parameter int               N_GROUPS      = 8,
    parameter int               HDR_W         = 8,
    parameter logic [HDR_W-1:0] SYNC_WORD     = 8'b01111110,
    parameter logic [HDR_W-1:0] ALT_SYNC_WORD = 8'b01101110
) (
    input logic                     clk_in,
    input logic                     rst,
    hamming_frame_encoder_if.slave  bus
);

    localparam int DATA_W = 4 * N_GROUPS;
`ifdef HAMMING_SECDED_EN
    localparam int CW_W = 8;
`else
    localparam int CW_W = 7;
`endif
    localparam int FRAME_W   = HDR_W + N_GROUPS * CW_W;
    localparam int BIT_CNT_W = $clog2(DATA_W);
    localparam int OUT_CNT_W = $clog2(FRAME_W);

    localparam logic [BIT_CNT_W-1:0] LAST_IN_BIT  = BIT_CNT_W'(DATA_W - 1);
    localparam logic [OUT_CNT_W-1:0] LAST_OUT_BIT = OUT_CNT_W'(FRAME_W - 1);

    // state   | meaning
    // --------+-----------------------------------------------------------
    // S_IDLE  | shifter empty, out_valid low, waiting for a pending payload
    // S_SHIFT | frame bit shifter[FRAME_W-1] presented on out_data
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [DATA_W-1:0]    data_reg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 pending;
    logic                 in_accept;

    logic [FRAME_W-1:0]   enc_frame;
    logic [FRAME_W-1:0]   shifter;
    logic [OUT_CNT_W-1:0] out_idx;
    logic [7:0]           frame_cnt;

    logic                 load;
    logic                 shift;

    // -------------------------------------------------------------------------
    // Nibble encoder
    // -------------------------------------------------------------------------
    function automatic logic [CW_W-1:0] encode_nibble(input logic [3:0] d);
        logic       p0;
        logic       p1;
        logic       p2;
        logic [6:0] cw7;
        p0  = d[0] ^ d[1] ^ d[3];
        p1  = d[0] ^ d[2] ^ d[3];
        p2  = d[1] ^ d[2] ^ d[3];
        cw7 = {d[3], d[2], d[1], p2, d[0], p1, p0};
`ifdef HAMMING_SECDED_EN
        return {^cw7, cw7};
`else
        return cw7;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Collect side. The payload register fills MSB first by shifting left;
    // once full it is frozen (in_ready low) until the output side loads it.
    // -------------------------------------------------------------------------
    assign in_accept = bus.in_valid && !pending;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            bit_cnt  <= '0;
            pending  <= 1'b0;
        end else begin
            if (in_accept) begin
                data_reg <= {data_reg[DATA_W-2:0], bus.in_data};
                bit_cnt  <= (bit_cnt == LAST_IN_BIT) ? '0 : bit_cnt + BIT_CNT_W'(1);
            end
            // Acceptance needs pending low and load needs it high, so the two
            // branches never compete in one cycle.
            if (in_accept && (bit_cnt == LAST_IN_BIT)) begin
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Frame assembly from the frozen payload; only consumed on a load edge,
    // which is also the only time hdr_sel matters.
    // -------------------------------------------------------------------------
    always_comb begin
        enc_frame = '0;
        enc_frame[FRAME_W-1 -: HDR_W] = bus.hdr_sel ? ALT_SYNC_WORD : SYNC_WORD;
        for (int g = 0; g < N_GROUPS; g++) begin
            enc_frame[CW_W*g +: CW_W] = encode_nibble(data_reg[4*g +: 4]);
        end
    end

    // -------------------------------------------------------------------------
    // Output FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.out_ready) begin
                    if (out_idx == LAST_OUT_BIT) begin
                        // Reloading on the last handshake keeps the stream
                        // gapless when the next payload is already waiting.
                        if (pending) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            shifter   <= '0;
            out_idx   <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                shifter   <= enc_frame;
                out_idx   <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end else if (shift) begin
                shifter <= {shifter[FRAME_W-2:0], 1'b0};
                out_idx <= out_idx + OUT_CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Everything is registered state, so it holds while out_ready is
    // low. out_data is gated so an idle line reads 0.
    // -------------------------------------------------------------------------
    assign bus.in_ready  = !pending;
    assign bus.out_valid = (state == S_SHIFT);
    assign bus.out_data  = (state == S_SHIFT) && shifter[FRAME_W-1];
    assign bus.out_sof   = (state == S_SHIFT) && (out_idx == '0);
    assign bus.frame_cnt = frame_cnt;

endmodule

// File: doc/hamming_frame_encoder.md
# hamming_frame_encoder

Parametrised bit-serial Hamming frame encoder: collects `4*N_GROUPS` serial data bits, encodes each nibble as a Hamming(7,4) codeword, prepends a selectable sync header, and shifts the frame out serially MSB first. Single clock domain with valid/ready handshakes on both sides. It double-buffers, so the next frame's payload is collected while the current frame shifts out. It replaces the fixed 32-bit, two-clock encoder in the transmit path, ahead of the line driver.

## Interface
- `N_GROUPS`, 8: nibbles per frame; `DATA_W = 4*N_GROUPS`.
- `HDR_W`, 8: header width in bits.
- `SYNC_WORD`, 8'b01111110: header used when `hdr_sel=0`.
- `ALT_SYNC_WORD`, 8'b01101110: header used when `hdr_sel=1`.
- `clk_in  in  1  clock, all logic on rising edge`
- `rst  in  1  asynchronous, active-high reset`
- `in_data  in  1  serial payload bit`
- `in_valid  in  1  in_data valid`
- `in_ready  out  1  block accepts in_data this cycle`
- `hdr_sel  in  1  header select, sampled at frame load`
- `out_data  out  1  serial frame bit`
- `out_valid  out  1  out_data valid`
- `out_ready  in  1  downstream accepts out_data`
- `out_sof  out  1  high with the first (MSB) header bit of each frame`
- `frame_cnt  out  8  frames loaded since reset, wraps 255→0`

## Operation
- Definitions: `CW_W` = 7, or 8 with SECDED; `FRAME_W = HDR_W + N_GROUPS*CW_W`.
- Collect side:
  - A bit is accepted when `in_valid && in_ready`.
  - The first accepted bit of a payload goes to `data[DATA_W-1]` and the last to `data[0]`.
  - The bit counter is `$clog2(DATA_W)` wide and wraps to 0 after bit `DATA_W-1`.
- Pending flag: set on acceptance of bit `DATA_W-1`. While it is set, `in_ready=0`.
- Encode, per group g, with nibble `d = data[4g+3:4g]`:
  - `p0=d0^d1^d3`, `p1=d0^d2^d3`, `p2=d1^d2^d3`.
  - `cw = {d3,d2,d1,p2,d0,p1,p0}`.
  - The codeword occupies `frame[CW_W*g +: CW_W]`.
  - The header occupies `frame[FRAME_W-1 -: HDR_W]`.
- Output FSM:
  - IDLE: `out_valid=0`. When pending, load the shifter with the encoded frame, clear pending, increment `frame_cnt`, and go to SHIFT.
  - SHIFT: `out_data = shifter[FRAME_W-1]`. On `out_valid && out_ready`, shift left one bit.
  - On the handshake of bit `FRAME_W-1`:
    - If pending, load the next frame in the same cycle and stay in SHIFT. This gives a gapless stream.
    - Otherwise go to IDLE.
- `out_sof` is high exactly while the shifter holds bit 0 of a frame, i.e. the first header bit.
- Backpressure: while `out_ready=0`, `out_data`, `out_valid` and `out_sof` hold their values.
- Reset: all outputs and state clear immediately, including a partial payload, the pending frame and a frame mid-shift.
- Reset values: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_sof=0`, `frame_cnt=0`.

## Timing
- Load latency: last payload bit accepted at edge N → `out_valid=1` with the first header bit after edge N+1, if the shifter was idle.
- Throughput: one bit per cycle on each side.
- Input stalls:
  - Sustained input stalls whenever a payload completes before the previous frame has loaded.
  - Once that frame loads, `in_ready` returns to 1 one cycle after the load edge.
- Collect-side events are independent of output activity, so payload collection overlaps shifting.
- Simultaneous events in one cycle (last output bit handshake + last input bit accept):
  - The accepted payload becomes pending at that edge and loads on the next edge.
  - Result: one idle output cycle.
- `hdr_sel` is sampled only on load edges.

## Configuration
- `HAMMING_SECDED_EN` defined:
  - `CW_W=8`; each codeword is `{^cw7, cw7}`, an overall-parity MSB that gives SEC-DED.
  - `FRAME_W = HDR_W + 8*N_GROUPS`.
- Undefined: plain Hamming(7,4), `CW_W=7`; default `FRAME_W=64`.

## Test plan
- Reset, then payload 0x00000000 with `hdr_sel=0`, `out_ready=1`:
  - 64 output bits = 0x7E followed by 56 zeros.
  - `out_sof` high on bit 0 only; `frame_cnt=1`.
- Payload 0xFFFFFFFF, then 0xBBBBBBBB with `hdr_sel=1`:
  - Frame 1 = 0x7E followed by 56 ones.
  - Frame 2 = 0x6E, then each 7-bit group 1010101.
  - With input valid on every cycle, frames are back-to-back with no `out_valid` gap; `frame_cnt=2`.
- `out_ready` toggled 1/0 every cycle during a frame:
  - Output stream identical to the unstalled case.
  - `in_ready` drops to 0 once the second payload is pending.
- `HAMMING_SECDED_EN`, payload 0xBBBBBBBB:
  - Each group = 8'b01010101.
  - Frame length 72 bits; header 0x7E.
- Assert `rst` mid-shift at bit 20 with 10 payload bits collected:
  - Next cycle `out_valid=0`, `in_ready=1`, `frame_cnt=0`.
  - A fresh payload then produces a correct frame.
- `frame_cnt` wrap: send 256 frames → count reads 0.
